// File: rtl/coin_sprite_reader.sv
// coin_sprite_reader: coin sprite ROM read pipeline with spin/collect sequencing; COIN_PINGPONG_EN selects ping-pong frame order
module coin_sprite_reader #(
    parameter int SPR_W = 20,
    parameter int STEP_TICKS = 8,
    parameter int RISE_TICKS = 16,
    parameter int RISE_PX = 2,
    parameter logic [11:0] KEY_COLOR = 12'h808
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  coin_x,
    input  logic [9:0]  coin_y,
    input  logic        coin_active,
    input  logic        collect,
    output logic [8:0]  read_address,
    output logic [1:0]  frame_sel,
    input  logic [11:0] rom_color,
    output logic [11:0] pixel_color,
    output logic        pixel_valid,
    output logic        busy
);
    localparam int SW = $clog2(STEP_TICKS);
    localparam int RW = $clog2(RISE_TICKS);
    localparam int YW = $clog2(RISE_TICKS * RISE_PX + 1);
    localparam logic signed [11:0] W = 12'(SPR_W);
    typedef enum logic [1:0] {IDLE, SPIN, COLLECTED} state_t;
    state_t state, nxt;
    logic fc_q, tick, hit, hit_q, opaque;
    logic [SW-1:0] step;
    logic [RW-1:0] rise;
    logic [YW-1:0] y_off;
    logic signed [11:0] top, rel_x, rel_y;
`ifdef COIN_PINGPONG_EN
    logic dir;
`endif
    assign tick = frame_clk & ~fc_q;
    assign busy = state != IDLE;
    // 12-bit signed keeps rows above the screen and right-edge sums from wrapping
    assign top = $signed({2'b00, coin_y}) - $signed(12'(y_off));
    assign rel_x = $signed({2'b00, DrawX}) - $signed({2'b00, coin_x});
    assign rel_y = $signed({2'b00, DrawY}) - top;
    assign hit = rel_x >= 12'sd0 && rel_x < W && rel_y >= 12'sd0 && rel_y < W;
    assign opaque = hit_q && busy && rom_color != KEY_COLOR;
    always_comb
        nxt = !coin_active ? IDLE :
              state == IDLE ? SPIN :
              (state == SPIN && collect) ? COLLECTED :
              (state == COLLECTED && tick && rise == RW'(RISE_TICKS - 1)) ? IDLE : state;
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
            fc_q <= 1'b0;
            hit_q <= 1'b0;
            read_address <= '0;
            frame_sel <= '0;
            pixel_color <= '0;
            pixel_valid <= 1'b0;
            step <= '0;
            rise <= '0;
            y_off <= '0;
`ifdef COIN_PINGPONG_EN
            dir <= 1'b0;
`endif
        end else begin
            state <= nxt;
            fc_q <= frame_clk;
            hit_q <= hit;
            read_address <= hit ? 9'(rel_y * W + rel_x) : 9'd0;
            pixel_valid <= opaque;
            pixel_color <= opaque ? rom_color : 12'h000;
            if (nxt == IDLE) begin
                step <= '0;
                frame_sel <= '0;
`ifdef COIN_PINGPONG_EN
                dir <= 1'b0;
`endif
            end else if (tick && busy) begin
                step <= step == SW'(STEP_TICKS - 1) ? '0 : step + 1'b1;
                if (step == SW'(STEP_TICKS - 1)) begin
`ifdef COIN_PINGPONG_EN
                    frame_sel <= dir ? frame_sel - 2'd1 : frame_sel + 2'd1;
                    dir <= dir ? frame_sel != 2'd1 : frame_sel == 2'd2;
`else
                    frame_sel <= frame_sel + 2'd1;
`endif
                end
            end
            if (!coin_active || (state == SPIN && nxt == COLLECTED)) begin
                y_off <= '0;
                rise <= '0;
            end else if (state == COLLECTED && tick) begin
                y_off <= y_off + YW'(RISE_PX);
                rise <= rise + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_coin_sprite_reader.sv
// tb_coin_sprite_reader: directed bench with expectation queue for the coin sprite reader
module tb_coin_sprite_reader;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, coin_x = '0, coin_y = '0;
    logic        coin_active = 1'b0, collect = 1'b0, rom_key = 1'b0;
    logic [8:0]  read_address;
    logic [1:0]  frame_sel;
    logic [11:0] rom_color, pixel_color;
    logic        pixel_valid, busy;
    int checks = 0, errors = 0;
    int ef = 0, ed = 0, np;
    typedef struct {logic [8:0] addr; logic v; logic [11:0] c;} exp_t;
    exp_t exp_q[$];
    exp_t e;

    assign rom_color = rom_key ? 12'h808 : {3'b001, read_address};

    coin_sprite_reader dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .DrawX(DrawX), .DrawY(DrawY), .coin_x(coin_x), .coin_y(coin_y),
        .coin_active(coin_active), .collect(collect),
        .read_address(read_address), .frame_sel(frame_sel), .rom_color(rom_color),
        .pixel_color(pixel_color), .pixel_valid(pixel_valid), .busy(busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int x, input int y, input int top, input bit bz, input bit key);
        exp_t r;
        bit h;
        h = x >= int'(coin_x) && x < int'(coin_x) + 20 && y >= top && y < top + 20;
        r.addr = h ? 9'((y - top) * 20 + (x - int'(coin_x))) : 9'd0;
        r.v = h && bz && !key;
        r.c = r.v ? {3'b001, r.addr} : 12'h000;
        return r;
    endfunction

    task automatic probe(input string tag, input int x, input int y, input int top, input bit bz, input bit key);
        DrawX = 10'(x);
        DrawY = 10'(y);
        rom_key = key;
        exp_q.push_back(model(x, y, top, bz, key));
        step();
        chk({tag, ".addr"}, 32'(read_address), 32'(exp_q[0].addr));
        step();
        e = exp_q.pop_front();
        chk({tag, ".valid"}, 32'(pixel_valid), 32'(e.v));
        chk({tag, ".color"}, 32'(pixel_color), 32'(e.c));
        rom_key = 1'b0;
    endtask

    task automatic pulse();
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        step();
    endtask

    task automatic advance();
`ifdef COIN_PINGPONG_EN
        ef = ed ? ef - 1 : ef + 1;
        if (ef == 3) ed = 1;
        if (ef == 0) ed = 0;
`else
        ef = (ef + 1) % 4;
`endif
    endtask

    initial begin
        // reset with inputs churning
        repeat (2) begin
            DrawX = 10'($urandom);
            DrawY = 10'($urandom);
            coin_x = DrawX;
            coin_y = DrawY;
            coin_active = 1'b1;
            collect = 1'b1;
            frame_clk = ~frame_clk;
            step();
        end
        chk("rst.addr", 32'(read_address), 32'd0);
        chk("rst.frame", 32'(frame_sel), 32'd0);
        chk("rst.color", 32'(pixel_color), 32'd0);
        chk("rst.valid", 32'(pixel_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        frame_clk = 1'b0;
        collect = 1'b0;
        coin_active = 1'b0;
        coin_x = 10'd100;
        coin_y = 10'd200;
        Reset_n = 1'b1;
        step();
        chk("idle.busy", 32'(busy), 32'd0);
        coin_active = 1'b1;
        step();
        chk("spin.busy", 32'(busy), 32'd1);
        // hit test and pipeline
        probe("hit", 105, 203, 200, 1, 0);
        probe("right", 120, 203, 200, 1, 0);
        probe("left", 99, 203, 200, 1, 0);
        probe("corner", 119, 219, 200, 1, 0);
        probe("origin", 100, 200, 200, 1, 0);
        probe("below", 105, 220, 200, 1, 0);
        probe("key", 105, 203, 200, 1, 1);
        // animation frames
`ifdef COIN_PINGPONG_EN
        np = 48;
`else
        np = 32;
`endif
        for (int p = 1; p <= np; p++) begin
            pulse();
            if (p % 8 == 0) begin
                advance();
                chk($sformatf("frame%0d", p / 8), 32'(frame_sel), 32'(ef));
            end
        end
        frame_clk = 1'b1;
        repeat (100) step();
        frame_clk = 1'b0;
        step();
        repeat (6) pulse();
        chk("hold.before", 32'(frame_sel), 32'(ef));
        pulse();
        advance();
        chk("hold.after", 32'(frame_sel), 32'(ef));
        // collect and rise
        collect = 1'b1;
        step();
        collect = 1'b0;
        chk("coll.busy", 32'(busy), 32'd1);
        repeat (5) pulse();
        probe("rise10", 105, 195, 190, 1, 0);
        collect = 1'b1;
        step();
        collect = 1'b0;
        probe("recollect", 105, 191, 190, 1, 0);
        repeat (10) pulse();
        probe("rise30", 105, 171, 170, 1, 0);
        frame_clk = 1'b1;
        step();
        chk("done.busy", 32'(busy), 32'd0);
        chk("done.frame", 32'(frame_sel), 32'd0);
        frame_clk = 1'b0;
        step();
        probe("rise32", 105, 171, 168, 1, 0);
        // inactive coin and priority over collect
        collect = 1'b1;
        coin_active = 1'b0;
        step();
        collect = 1'b0;
        chk("prio.busy", 32'(busy), 32'd0);
        probe("inactive", 105, 203, 200, 0, 0);
        coin_active = 1'b1;
        step();
        chk("respin.busy", 32'(busy), 32'd1);
        collect = 1'b1;
        step();
        collect = 1'b0;
        repeat (3) pulse();
        Reset_n = 1'b0;
        step();
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.frame", 32'(frame_sel), 32'd0);
        Reset_n = 1'b1;
        step();
        chk("abort.spin", 32'(busy), 32'd1);
        probe("yoff0", 105, 203, 200, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
